// File: rtl/ct_stream_packer.sv
// Ciphertext packer: fetches the u and v polynomial coefficients, compresses each one,
// packs the compressed values little-endian and streams the result out as bytes.
module ct_stream_packer #(
    parameter int KYBER_K = 2,
    parameter int KYBER_N = 256,
    parameter int KYBER_Q = 3329,
    parameter int DU      = 10,
    parameter int DV      = 4,
    parameter int COEF_W  = 12,
    parameter int RD_LAT  = 1,
    parameter int ADDR_W  = $clog2((KYBER_K + 1) * KYBER_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [COEF_W-1:0] rd_data,
    output logic [7:0]        o_byte,
    output logic              o_valid,
    output logic              o_last,
    input  logic              i_ready
);

    localparam int POLY_W = $clog2(KYBER_K + 1);
    localparam int IDX_W  = $clog2(KYBER_N);
    localparam int TOTAL  = (KYBER_K * KYBER_N * DU + KYBER_N * DV) / 8;
    localparam int BCNT_W = $clog2(TOTAL + 1);
    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_MERGE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [23:0]         acc_q, acc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [POLY_W-1:0]   poly_q, poly_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                fin_q, fin_d;

    logic [4:0]          d_cur;
    logic [31:0]         comp_num;
    logic [31:0]         comp_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            poly_q  <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            wait_q  <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            poly_q  <= poly_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            wait_q  <= wait_d;
            fin_q   <= fin_d;
        end
    end

    // Exact rounding division by the constant modulus; the final mask gives the mod 2^d wrap.
    always_comb begin
        d_cur    = (poly_q == POLY_W'(KYBER_K)) ? 5'(DV) : 5'(DU);
        comp_num = (32'(rd_data) << d_cur) + 32'(KYBER_Q / 2);
        comp_c   = (comp_num / 32'(KYBER_Q)) & ((32'd1 << d_cur) - 32'd1);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        poly_d  = poly_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        wait_d  = wait_q;
        fin_d   = fin_q;
        rd_en   = 1'b0;
        o_valid = 1'b0;
        o_last  = 1'b0;
        done    = 1'b0;
        busy    = (state_q != S_IDLE) && (state_q != S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    poly_d  = '0;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    fin_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en  = 1'b1;
                wait_d = '0;
                if (RD_LAT > 1) state_d = S_WAIT;
                else            state_d = S_MERGE;
            end
            S_WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                if (wait_q == WAIT_W'(RD_LAT - 2)) state_d = S_MERGE;
            end
            S_MERGE: begin
                acc_d = acc_q | 24'(comp_c << cnt_q);
                cnt_d = cnt_q + d_cur;
                if (idx_q == IDX_W'(KYBER_N - 1)) begin
                    idx_d = '0;
                    if (poly_q == POLY_W'(KYBER_K)) fin_d = 1'b1;
                    else                            poly_d = poly_q + POLY_W'(1);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Whole bytes leave before the next fetch, so no read is issued while cnt >= 8.
                if (cnt_q >= 5'd8) begin
                    o_valid = 1'b1;
                    o_last  = (bcnt_q == BCNT_W'(TOTAL - 1));
                    if (i_ready) begin
                        acc_d  = acc_q >> 8;
                        cnt_d  = cnt_q - 5'd8;
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end else if (fin_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_byte  = acc_q[7:0];
    assign rd_addr = ADDR_W'(poly_q) * ADDR_W'(KYBER_N) + ADDR_W'(idx_q);

endmodule

// File: tb/tb_ct_stream_packer.sv
// Scoreboard bench for ct_stream_packer: a K=2/DU=10/DV=4/RD_LAT=1 instance and a
// K=4/DU=11/DV=5/RD_LAT=3 instance, each with its own RAM model, queue and monitor.
module tb_ct_stream_packer;

    localparam int BUDGET = 20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;

    // Instance 0: K=2, DU=10, DV=4, RD_LAT=1
    logic        start0, busy0, done0, rd_en0, o_valid0, o_last0, i_ready0;
    logic [9:0]  rd_addr0;
    logic [11:0] rd_data0;
    logic [7:0]  o_byte0;
    logic [11:0] mem0 [768];
    logic [8:0]  exp0 [$];
    int          rd_cnt0 = 0, done_cnt0 = 0;
    bit          stall0 = 1'b0;
    logic [7:0]  held0;

    // Instance 1: K=4, DU=11, DV=5, RD_LAT=3
    logic        start1, busy1, done1, rd_en1, o_valid1, o_last1, i_ready1;
    logic [10:0] rd_addr1;
    logic [11:0] rd_data1, pipe1a, pipe1b;
    logic [7:0]  o_byte1;
    logic [11:0] mem1 [1280];
    logic [8:0]  exp1 [$];
    int          rd_cnt1 = 0, done_cnt1 = 0;
    bit          stall1 = 1'b0;
    logic [7:0]  held1;

    ct_stream_packer #(.KYBER_K(2), .DU(10), .DV(4), .RD_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .o_byte(o_byte0), .o_valid(o_valid0), .o_last(o_last0), .i_ready(i_ready0)
    );

    ct_stream_packer #(.KYBER_K(4), .DU(11), .DV(5), .RD_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .o_byte(o_byte1), .o_valid(o_valid1), .o_last(o_last1), .i_ready(i_ready1)
    );

    // RAM models; 12'hABC marks cycles where rd_data is not meant to be sampled
    always @(posedge clk) begin
        rd_data0 <= rd_en0 ? mem0[rd_addr0] : 12'hABC;
        pipe1a   <= rd_en1 ? mem1[rd_addr1] : 12'hABC;
        pipe1b   <= pipe1a;
        rd_data1 <= pipe1b;
        if (rd_en0) rd_cnt0 <= rd_cnt0 + 1;
        if (rd_en1) rd_cnt1 <= rd_cnt1 + 1;
    end

    always @(posedge clk) begin
        #1;
        i_ready0 = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        i_ready1 = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitors: compare each transferred byte with the queue head and check stall stability
    always @(negedge clk) begin
        if (rst) begin
            stall0 = 1'b0;
        end else begin
            if (stall0) begin
                chk("hold_valid0", {31'd0, o_valid0}, 32'd1);
                chk("hold_byte0", {24'd0, o_byte0}, {24'd0, held0});
            end
            if (o_valid0) chk("rd_while_valid0", {31'd0, rd_en0}, 32'd0);
            if (o_valid0 && i_ready0) begin
                stall0 = 1'b0;
                if (exp0.size() == 0) chk("extra_byte0", {23'd0, o_last0, o_byte0}, 32'h1FF);
                else chk("byte0", {23'd0, o_last0, o_byte0}, {23'd0, exp0.pop_front()});
            end else if (o_valid0) begin
                stall0 = 1'b1;
                held0  = o_byte0;
            end else begin
                stall0 = 1'b0;
            end
        end
        if (done0) done_cnt0++;
    end

    always @(negedge clk) begin
        if (rst) begin
            stall1 = 1'b0;
        end else begin
            if (stall1) begin
                chk("hold_valid1", {31'd0, o_valid1}, 32'd1);
                chk("hold_byte1", {24'd0, o_byte1}, {24'd0, held1});
            end
            if (o_valid1) chk("rd_while_valid1", {31'd0, rd_en1}, 32'd0);
            if (o_valid1 && i_ready1) begin
                stall1 = 1'b0;
                if (exp1.size() == 0) chk("extra_byte1", {23'd0, o_last1, o_byte1}, 32'h1FF);
                else chk("byte1", {23'd0, o_last1, o_byte1}, {23'd0, exp1.pop_front()});
            end else if (o_valid1) begin
                stall1 = 1'b1;
                held1  = o_byte1;
            end else begin
                stall1 = 1'b0;
            end
        end
        if (done1) done_cnt1++;
    end

    // Reference encoder: rounded compression, then bit-serial little-endian packing
    function automatic void push_model(input int inst);
        int k, du, dv, d, total, nbytes, bitpos;
        longint x, c;
        logic [7:0] cur;
        k = (inst == 0) ? 2 : 4;
        du = (inst == 0) ? 10 : 11;
        dv = (inst == 0) ? 4 : 5;
        total = (k * 256 * du + 256 * dv) / 8;
        nbytes = 0;
        bitpos = 0;
        cur = 8'd0;
        for (int p = 0; p <= k; p++) begin
            d = (p < k) ? du : dv;
            for (int i = 0; i < 256; i++) begin
                x = (inst == 0) ? longint'(mem0[p * 256 + i]) : longint'(mem1[p * 256 + i]);
                c = (2 * x * (longint'(1) << d) + 3329) / (2 * 3329);
                c = c % (longint'(1) << d);
                for (int b = 0; b < d; b++) begin
                    cur[bitpos % 8] = ((c >> b) & 1) != 0;
                    if (bitpos % 8 == 7) begin
                        if (inst == 0) exp0.push_back({nbytes == total - 1, cur});
                        else           exp1.push_back({nbytes == total - 1, cur});
                        nbytes++;
                        cur = 8'd0;
                    end
                    bitpos++;
                end
            end
        end
    endfunction

    // Hand-computed stream for x=4 everywhere: u coefficients compress to 1, v to 0
    task automatic push_x4_pattern();
        logic [7:0] pat [5];
        pat = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h00};
        for (int i = 0; i < 768; i++) begin
            if (i < 640) exp0.push_back({1'b0, pat[i % 5]});
            else         exp0.push_back({i == 767, 8'h00});
        end
    endtask

    task automatic apply_stimulus(input int inst);
        if (inst == 0) begin rd_cnt0 = 0; done_cnt0 = 0; end
        else           begin rd_cnt1 = 0; done_cnt1 = 0; end
        @(posedge clk); #1;
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int inst);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if ((inst == 0 && done0) || (inst == 1 && done1)) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic check_output(input int inst, input string tag);
        repeat (4) @(negedge clk);
        if (inst == 0) begin
            chk({tag, "_queue_empty"}, exp0.size(), 32'd0);
            chk({tag, "_reads"}, rd_cnt0, 32'd768);
            chk({tag, "_done_count"}, done_cnt0, 32'd1);
            chk({tag, "_busy_after"}, {31'd0, busy0}, 32'd0);
        end else begin
            chk({tag, "_queue_empty"}, exp1.size(), 32'd0);
            chk({tag, "_reads"}, rd_cnt1, 32'd1280);
            chk({tag, "_done_count"}, done_cnt1, 32'd1);
            chk({tag, "_busy_after"}, {31'd0, busy1}, 32'd0);
        end
        exp0.delete();
        exp1.delete();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy0"}, {31'd0, busy0}, 32'd0);
        chk({tag, "_done0"}, {31'd0, done0}, 32'd0);
        chk({tag, "_rd_en0"}, {31'd0, rd_en0}, 32'd0);
        chk({tag, "_rd_addr0"}, {22'd0, rd_addr0}, 32'd0);
        chk({tag, "_out0"}, {22'd0, o_valid0, o_last0, o_byte0}, 32'd0);
        chk({tag, "_busy1"}, {31'd0, busy1}, 32'd0);
        chk({tag, "_rd_en1"}, {31'd0, rd_en1}, 32'd0);
        chk({tag, "_out1"}, {22'd0, o_valid1, o_last1, o_byte1}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        i_ready0 = 1'b1;
        i_ready1 = 1'b1;
        #12;
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] x=4 stream");
        for (int i = 0; i < 768; i++) mem0[i] = 12'd4;
        push_x4_pattern();
        apply_stimulus(0);
        wait_done(0);
        check_output(0, "x4");

        $display("[TB] compression edges");
        for (int i = 0; i < 768; i++) mem0[i] = 12'd0;
        mem0[0] = 12'd1664;
        mem0[1] = 12'd3328;
        mem0[2] = 12'd1;
        mem0[512] = 12'd1664;
        mem0[513] = 12'd3328;
        for (int i = 0; i < 768; i++) begin
            if (i == 1)        exp0.push_back({1'b0, 8'h02});
            else if (i == 640) exp0.push_back({1'b0, 8'h08});
            else               exp0.push_back({i == 767, 8'h00});
        end
        apply_stimulus(0);
        wait_done(0);
        check_output(0, "edges");

        $display("[TB] coefficient ramp");
        for (int i = 0; i < 768; i++) mem0[i] = 12'((i * 13) % 3329);
        mem0[767] = 12'd3328;
        push_model(0);
        apply_stimulus(0);
        wait_done(0);
        check_output(0, "ramp");

        $display("[TB] backpressure");
        rand_ready = 1'b1;
        for (int i = 0; i < 768; i++) mem0[i] = 12'd4;
        push_x4_pattern();
        apply_stimulus(0);
        wait_done(0);
        check_output(0, "stall");

        $display("[TB] K=4 random RAM, RD_LAT=3");
        for (int i = 0; i < 1280; i++) mem1[i] = 12'($urandom_range(0, 3328));
        mem1[0] = 12'd0;
        mem1[1] = 12'd1664;
        mem1[1024] = 12'd3328;
        push_model(1);
        apply_stimulus(1);
        wait_done(1);
        check_output(1, "k4");
        rand_ready = 1'b0;

        $display("[TB] reset mid-run");
        for (int i = 0; i < 768; i++) mem0[i] = 12'd4;
        push_x4_pattern();
        apply_stimulus(0);
        repeat (40) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_quiet("midreset");
        exp0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_no_done", done_cnt0, 32'd0);
        push_x4_pattern();
        apply_stimulus(0);
        wait_done(0);
        check_output(0, "restart");

        $display("[TB] start while busy and with done");
        push_x4_pattern();
        apply_stimulus(0);
        repeat (50) @(posedge clk);
        #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < BUDGET; n++) begin
                @(negedge clk);
                if (done0) begin
                    seen = 1'b1;
                    start0 = 1'b1;
                    break;
                end
            end
            chk("busy_done_seen", {31'd0, seen}, 32'd1);
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("ignored_start_busy", {31'd0, busy0}, 32'd0);
        chk("ignored_start_rd_en", {31'd0, rd_en0}, 32'd0);
        check_output(0, "ignored");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
